fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the register-file/decode stage.
- Owns the architectural program counter and issues one word request at a time to instruction memory over a req/ack handshake.
- Presents each fetched instruction and its PC to decode through a single output register with valid/stall flow control.
- Accepts branch redirects and discards any fetch that a redirect has made stale.

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time to
// instruction memory and hands fetched words to decode through a stallable register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_addr;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_fetch_addr_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_instr_nxt;
  logic [31:0] w_if_pc_nxt;
  logic        w_skid_valid_nxt;
  logic [31:0] w_skid_instr_nxt;
  logic [31:0] w_skid_pc_nxt;

  logic        w_slot_free;
  logic [31:0] w_target;
  logic [31:0] w_step_addr;

  assign w_slot_free = !r_if_valid || !stall;
  assign w_target    = redirect_pc & ~32'h3;
  assign w_step_addr = r_fetch_addr + PC_STEP;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_addr_nxt = r_fetch_addr;
    w_if_valid_nxt   = r_if_valid;
    w_if_instr_nxt   = r_if_instr;
    w_if_pc_nxt      = r_if_pc;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;

    // Decode takes the current word whenever the slot is free.
    if (w_slot_free) w_if_valid_nxt = 1'b0;

    if (redirect) begin
      w_pc_nxt         = w_target;
      w_if_valid_nxt   = 1'b0;
      w_skid_valid_nxt = 1'b0;
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            w_fetch_addr_nxt = w_target;
            w_state_nxt      = FETCH;
          end else begin
            w_state_nxt = DROP;
          end
        end
        DROP: begin
          // A stale request still in flight must be absorbed before refetching.
          if (imem_ack) begin
            w_fetch_addr_nxt = w_target;
            w_state_nxt      = enable ? FETCH : IDLE;
          end
        end
        default: begin
          w_fetch_addr_nxt = w_target;
          w_state_nxt      = enable ? FETCH : IDLE;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && !r_skid_valid) begin
            w_fetch_addr_nxt = r_pc;
            w_state_nxt      = FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            w_pc_nxt = w_step_addr;
            if (w_slot_free) begin
              w_if_valid_nxt   = 1'b1;
              w_if_instr_nxt   = imem_rdata;
              w_if_pc_nxt      = r_fetch_addr;
              w_fetch_addr_nxt = w_step_addr;
              w_state_nxt      = enable ? FETCH : IDLE;
            end else begin
              w_skid_valid_nxt = 1'b1;
              w_skid_instr_nxt = imem_rdata;
              w_skid_pc_nxt    = r_fetch_addr;
              w_state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (w_slot_free) begin
            w_if_valid_nxt   = 1'b1;
            w_if_instr_nxt   = r_skid_instr;
            w_if_pc_nxt      = r_skid_pc;
            w_skid_valid_nxt = 1'b0;
            w_fetch_addr_nxt = r_pc;
            w_state_nxt      = enable ? FETCH : IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            w_fetch_addr_nxt = r_pc;
            w_state_nxt      = enable ? FETCH : IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC_AL;
      r_fetch_addr <= RESET_PC_AL;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'h0;
      r_if_pc      <= 32'h0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_if_instr   <= w_if_instr_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  // Skid data is qualified by r_skid_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    r_skid_instr <= w_skid_instr_nxt;
    r_skid_pc    <= w_skid_pc_nxt;
  end

  assign pc        = r_pc;
  assign imem_req  = (r_state == FETCH) || (r_state == DROP);
  assign imem_addr = r_fetch_addr;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model and
// hand-computed expectations for streaming, waits, stall, redirects, wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 0;
  int cnt    = 0;

  fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  // Memory acks once a request has been waiting lat cycles.
  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                       cnt <= 0;
  end
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
    chk({tag, "_pc"}, if_pc, exp_pc);
    chk({tag, "_instr"}, if_instr, exp_pc ^ KEY);
  endtask

  initial begin
    // Reset values and zero-wait streaming
    reset = 1'b1; enable = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    lat = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_ifpc", if_pc, 32'h0);
    do_reset(); enable = 1'b1;
    step();
    chk("c1_req", {31'h0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", {31'h0, if_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_word("stream", 32'(4 * k));
    end

    // Three-cycle memory latency
    do_reset(); enable = 1'b1; lat = 3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wait_addr0", imem_addr, 32'h0);
      chk("wait_valid0", {31'h0, if_valid}, 32'h0);
    end
    step();
    step();
    chk_word("lat_w0", 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("gap_valid", {31'h0, if_valid}, 32'h0);
      chk("wait_addr4", imem_addr, 32'h4);
    end
    step();
    chk_word("lat_w1", 32'h4);

    // Stall with a completing fetch goes through the skid buffer
    do_reset(); enable = 1'b1; lat = 0;
    step(); step(); step(); step();
    chk_word("pre_stall", 32'h8);
    stall = 1'b1;
    step();
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_pc", pc, 32'h10);
    chk_word("held5", 32'h8);
    step(); chk_word("held6", 32'h8);
    step(); chk_word("held7", 32'h8);
    stall = 1'b0;
    step();
    chk_word("skid_out", 32'hC);
    step();
    chk_word("after_skid", 32'h10);

    // Redirect while a request is outstanding
    do_reset(); enable = 1'b1; lat = 0;
    step(); step(); step(); step(); step();
    chk_word("pre_redir", 32'hC);
    lat = 2; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("drop_pc", pc, 32'h100);
    chk("drop_req", {31'h0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_valid6", {31'h0, if_valid}, 32'h0);
    step();
    chk("drop_valid7", {31'h0, if_valid}, 32'h0);
    chk("drop_addr7", imem_addr, 32'h10);
    step();
    chk("drop_valid8", {31'h0, if_valid}, 32'h0);
    chk("tgt_addr", imem_addr, 32'h100);
    lat = 0;
    step();
    chk_word("tgt_word", 32'h100);

    // Redirect coincident with ack, unaligned target
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("coin_pc", pc, 32'h200);
    chk("coin_valid", {31'h0, if_valid}, 32'h0);
    chk("coin_addr", imem_addr, 32'h200);
    step();
    chk_word("coin_word", 32'h200);

    // Wrap of the PC past the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_valid", {31'h0, if_valid}, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk_word("wrap_top", 32'hFFFF_FFFC);
    step();
    chk_word("wrap_zero", 32'h0);

    // Reset in the middle of a pending fetch
    stall = 1'b1; lat = 3;
    step();
    chk_word("pre_rst", 32'h0);
    chk("pre_rst_pc", pc, 32'h4);
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_rst_instr", if_instr, 32'h0);
    chk("mid_rst_ifpc", if_pc, 32'h0);
    reset = 1'b0; stall = 1'b0; enable = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
